// File: rtl/uc_seq.sv
// Sequencing control unit for the microc datapath: opcode/z decode into the
// control word, datapath boot reset, HALT, illegal-opcode flag and retire count.
module uc_seq #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [5:0]       opcode_i,
  input  logic             z_i,
  output logic             s_abs_o,
  output logic             s_inc_o,
  output logic             s_inm_o,
  output logic             we3_o,
  output logic             wez_o,
  output logic [2:0]       op_o,
  output logic             dp_reset_o,
  output logic             halted_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  // state   | meaning
  // BOOT    | datapath held in reset for BOOT_CYCLES edges
  // RUN     | decoding one instruction per cycle
  // HALT    | PC frozen, no writes, left only through reset
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [5:0] OPC_HALT  = 6'b111111;
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             dec_illegal;

  // Only J/JZ/JNZ/JR are defined in the 10 group; only NOP/HALT in the 11 group.
  assign dec_illegal = ((opcode_i[5:4] == 2'b10) && (opcode_i[3:2] != 2'b00)) ||
                       ((opcode_i[5:4] == 2'b11) && (opcode_i[3:1] != 3'b111));

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      illegal_q  <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      illegal_q  <= illegal_d;
      retired_q  <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    illegal_d  = illegal_q;
    retired_d  = retired_q;
    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
        else                         boot_cnt_d = boot_cnt_q + 4'd1;
      end
      ST_RUN: begin
        if (opcode_i == OPC_HALT) state_d = ST_HALT;
        if (dec_illegal)          illegal_d = 1'b1;
        if (retired_q != '1)      retired_d = retired_q + CNT_W'(1);
      end
      ST_HALT: ;
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    s_abs_o    = 1'b0;
    s_inc_o    = 1'b1;
    s_inm_o    = 1'b0;
    we3_o      = 1'b0;
    wez_o      = 1'b0;
    op_o       = 3'b000;
    dp_reset_o = 1'b0;
    halted_o   = 1'b0;
    if (!reset_i) begin
      dp_reset_o = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          case (opcode_i[5:4])
            2'b00: begin
              op_o  = opcode_i[2:0];
              we3_o = 1'b1;
              wez_o = 1'b1;
            end
            2'b01: begin
              s_inm_o = 1'b1;
              we3_o   = 1'b1;
            end
            2'b10: begin
              case (opcode_i[3:0])
                4'b0000: begin s_abs_o = 1'b1; s_inc_o = 1'b0;  end
                4'b0001: begin s_abs_o = 1'b1; s_inc_o = ~z_i;  end
                4'b0010: begin s_abs_o = 1'b1; s_inc_o = z_i;   end
                4'b0011: s_inc_o = 1'b0;
                default: ;
              endcase
            end
            default: begin
              if (opcode_i == OPC_HALT) s_inc_o = 1'b0;
            end
          endcase
        end
        ST_HALT: begin
          s_inc_o  = 1'b0;
          halted_o = 1'b1;
        end
        default: dp_reset_o = 1'b1;
      endcase
    end
  end

  assign illegal_o = illegal_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_uc_seq.sv
// Scoreboard bench for uc_seq: expected control words are queued as stimulus
// is applied and popped when the DUT outputs are sampled.
module tb_uc_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  opcode = 6'b111110;
  logic        z = 1'b0;

  logic        s_abs, s_inc, s_inm, we3, wez, dp_reset, halted, illegal;
  logic [2:0]  op;
  logic [15:0] retired;

  logic        s_abs4, s_inc4, s_inm4, we34, wez4, dp_reset4, halted4, illegal4;
  logic [2:0]  op4;
  logic [3:0]  retired4;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  // word layout: {s_abs, s_inc, s_inm, we3, wez, op[2:0], dp_reset, halted}
  localparam logic [9:0] W_BOOT = 10'b0_1_0_0_0_000_1_0;
  localparam logic [9:0] W_HALT = 10'b0_0_0_0_0_000_0_1;

  uc_seq dut (
    .clk_i(clk), .reset_i(reset_n), .opcode_i(opcode), .z_i(z),
    .s_abs_o(s_abs), .s_inc_o(s_inc), .s_inm_o(s_inm), .we3_o(we3), .wez_o(wez),
    .op_o(op), .dp_reset_o(dp_reset), .halted_o(halted), .illegal_o(illegal),
    .retired_o(retired)
  );

  uc_seq #(.BOOT_CYCLES(2), .CNT_W(4)) dut4 (
    .clk_i(clk), .reset_i(reset_n), .opcode_i(opcode), .z_i(z),
    .s_abs_o(s_abs4), .s_inc_o(s_inc4), .s_inm_o(s_inm4), .we3_o(we34), .wez_o(wez4),
    .op_o(op4), .dp_reset_o(dp_reset4), .halted_o(halted4), .illegal_o(illegal4),
    .retired_o(retired4)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] cw_now();
    return {s_abs, s_inc, s_inm, we3, wez, op, dp_reset, halted};
  endfunction

  function automatic logic [9:0] cw4_now();
    return {s_abs4, s_inc4, s_inm4, we34, wez4, op4, dp_reset4, halted4};
  endfunction

  // Reference decode of one RUN-state instruction.
  function automatic logic [9:0] ref_run(input logic [5:0] o, input logic zz);
    logic [7:0] w;
    w = 8'b0_1_0_0_0_000;
    if (o[5:4] == 2'b00)      w = {5'b01011, o[2:0]};
    else if (o[5:4] == 2'b01) w = 8'b0_1_1_1_0_000;
    else if (o == 6'b100000)  w = 8'b1_0_000_000;
    else if (o == 6'b100001)  w = {1'b1, ~zz, 6'b0};
    else if (o == 6'b100010)  w = {1'b1, zz, 6'b0};
    else if (o == 6'b100011)  w = 8'b0;
    else if (o == 6'b111111)  w = 8'b0;
    return {w, 2'b00};
  endfunction

  // Applies inputs at the falling edge and lets combinational outputs settle.
  task automatic drive(input logic r, input logic [5:0] o, input logic zz);
    @(negedge clk);
    reset_n = r;
    opcode  = o;
    z       = zz;
    #1;
  endtask

  task automatic step(input logic r, input logic [5:0] o, input logic zz, input logic [9:0] e);
    drive(r, o, zz);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    drive(1'b0, 6'b111110, 1'b0);
    drive(1'b1, 6'b111110, 1'b0);
    drive(1'b1, 6'b111110, 1'b0);
  endtask

  task automatic test_reset();
    logic [9:0] e, g;
    for (int i = 0; i < 6; i++) begin
      step(i >= 2, 6'b010000, 1'b0, (i < 4) ? W_BOOT : ref_run(6'b010000, 1'b0));
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL reset_cw[%0d] got %b exp %b", i, g, e); end
      if (i >= 1) begin
        n_cmp++;
        if (retired !== ((i >= 5) ? 16'd1 : 16'd0)) begin
          n_bad++; $display("FAIL reset_retired[%0d] got %0d", i, retired);
        end
        n_cmp++;
        if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal[%0d] got %b exp 0", i, illegal); end
      end
    end
  endtask

  task automatic test_alu();
    logic [9:0] e, g;
    logic [5:0] o;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      o = (i < 8) ? 6'(i) : ((i == 8) ? 6'b001011 : 6'b001101);
      step(1'b1, o, i[0], ref_run(o, i[0]));
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL alu_cw[%0d] op=%b got %b exp %b", i, o, g, e); end
      n_cmp++;
      if (retired !== 16'(i)) begin n_bad++; $display("FAIL alu_retired[%0d] got %0d exp %0d", i, retired, i); end
    end
  endtask

  task automatic test_cond_jumps();
    logic [9:0] e, g;
    logic [5:0] o_tab [8] = '{6'b100001, 6'b100001, 6'b100010, 6'b100010,
                              6'b100000, 6'b100011, 6'b000101, 6'b100001};
    logic       z_tab [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, o_tab[i], z_tab[i], ref_run(o_tab[i], z_tab[i]));
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL jump_cw[%0d] op=%b z=%b got %b exp %b", i, o_tab[i], z_tab[i], g, e); end
    end
    drive(1'b1, 6'b111110, 1'b0);
    n_cmp++;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL jump_illegal got %b exp 0", illegal); end
  endtask

  task automatic test_halt();
    logic [9:0] e, g;
    logic [5:0] o_tab [4] = '{6'b000001, 6'b010101, 6'b111110, 6'b111111};
    logic [5:0] o;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, o_tab[i], 1'b0, ref_run(o_tab[i], 1'b0));
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL halt_seq_cw[%0d] got %b exp %b", i, g, e); end
    end
    for (int i = 0; i < 6; i++) begin
      o = 6'($urandom_range(0, 63));
      step(1'b1, o, 1'($urandom_range(0, 1)), W_HALT);
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL halt_cw[%0d] op=%b got %b exp %b", i, o, g, e); end
      n_cmp++;
      if (retired !== 16'd4) begin n_bad++; $display("FAIL halt_retired[%0d] got %0d exp 4", i, retired); end
    end
    n_cmp++;
    if (illegal !== 1'b0) begin n_bad++; $display("FAIL halt_illegal got %b exp 0", illegal); end
  endtask

  task automatic test_illegal();
    logic [9:0] e, g;
    logic [5:0] o_tab [6] = '{6'b101010, 6'b111111, 6'b000001, 6'b000001, 6'b000001, 6'b000001};
    logic       r_tab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [9:0] w_tab [6];
    logic       i_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    w_tab = '{ref_run(6'b101010, 1'b0), ref_run(6'b111111, 1'b0), W_HALT, W_BOOT, W_BOOT, W_BOOT};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(r_tab[i], o_tab[i], 1'b0, w_tab[i]);
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL illegal_cw[%0d] got %b exp %b", i, g, e); end
      n_cmp++;
      if (illegal !== i_tab[i]) begin n_bad++; $display("FAIL illegal_flag[%0d] got %b exp %b", i, illegal, i_tab[i]); end
    end
    step(1'b1, 6'b110000, 1'b0, ref_run(6'b110000, 1'b0));
    e = exp_q.pop_front(); g = cw_now(); n_cmp++;
    if (g !== e) begin n_bad++; $display("FAIL illegal2_cw got %b exp %b", g, e); end
    drive(1'b1, 6'b111110, 1'b0);
    n_cmp++;
    if (illegal !== 1'b1) begin n_bad++; $display("FAIL illegal2_flag got %b exp 1", illegal); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e, g;
    logic [5:0] o_tab [10] = '{6'b000010, 6'b000011, 6'b000011, 6'b000100, 6'b000100,
                               6'b000100, 6'b111111, 6'b010000, 6'b010000, 6'b010000};
    logic       r_tab [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [9:0] w_tab [10];
    int         ret_tab [10] = '{0, 1, 2, 0, 0, 0, 1, 2, 2, 0};
    w_tab = '{ref_run(6'b000010, 1'b0), ref_run(6'b000011, 1'b0), W_BOOT, W_BOOT, W_BOOT,
              ref_run(6'b000100, 1'b0), ref_run(6'b111111, 1'b0), W_HALT, W_BOOT, W_BOOT};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(r_tab[i], o_tab[i], 1'b0, w_tab[i]);
      e = exp_q.pop_front(); g = cw_now(); n_cmp++;
      if (g !== e) begin n_bad++; $display("FAIL rstmid_cw[%0d] got %b exp %b", i, g, e); end
      n_cmp++;
      if (retired !== 16'(ret_tab[i])) begin
        n_bad++; $display("FAIL rstmid_retired[%0d] got %0d exp %0d", i, retired, ret_tab[i]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] e, g, g4;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(1'b1, 6'b010011, 1'b0, ref_run(6'b010011, 1'b0));
      e = exp_q.pop_front(); g = cw_now(); g4 = cw4_now(); n_cmp++;
      if (g !== e || g4 !== e) begin n_bad++; $display("FAIL sat_cw[%0d] got %b/%b exp %b", i, g, g4, e); end
      n_cmp++;
      if (retired4 !== 4'((i > 15) ? 15 : i)) begin
        n_bad++; $display("FAIL sat_retired4[%0d] got %0d exp %0d", i, retired4, (i > 15) ? 15 : i);
      end
      n_cmp++;
      if (retired !== 16'(i)) begin n_bad++; $display("FAIL sat_retired16[%0d] got %0d exp %0d", i, retired, i); end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_cond_jumps();
    test_halt();
    test_illegal();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached after %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
